div_seq: RTL

//   Iterative radix-2 restoring divider with its own sequencer for DIV/DIVU in the EX stage.

---
 rtl/div_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU. It returns {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: when defined, a zero divisor completes one cycle after it is issued.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] result_o
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic               accept;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   dvd_reg, dvs_reg, opa_reg, rem_reg, quo_reg;
  logic               neg_q_reg, neg_r_reg, dzero_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i && !annul_i) begin
          accept  = 1'b1;
          stall_o = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          state_next = (opb_i == '0) ? DONE : PREP;
`else
          state_next = PREP;
`endif
        end
      end
      PREP: begin
        stall_o    = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        stall_o = 1'b1;
        if (cnt_reg == CNT_W'(1)) state_next = FIX;
      end
      FIX: begin
        stall_o    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        valid_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (annul_i) state_next = IDLE;
  end

  // The shifted remainder needs one extra bit; the trial difference's top bit is its sign.
  assign rem_sh  = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_reg};
  assign quo_fix = neg_q_reg ? -quo_reg : quo_reg;
  assign rem_fix = neg_r_reg ? -rem_reg : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      opa_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dzero_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            opa_reg   <= opa_i;
            dzero_reg <= (opb_i == '0);
            neg_r_reg <= signed_i & opa_i[WIDTH-1];
            neg_q_reg <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            dvd_reg   <= (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
            dvs_reg   <= (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
`ifdef DIV_ZERO_FAST_EN
            if (opb_i == '0) result_reg <= {opa_i, {WIDTH{1'b1}}};
`endif
          end
        end
        PREP: begin
          rem_reg <= '0;
          quo_reg <= dvd_reg;
          cnt_reg <= CNT_W'(WIDTH);
        end
        ITER: begin
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= rem_sh[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        FIX: begin
          // An annul here returns to IDLE, so the previous result must survive.
          if (!annul_i) begin
            if (dzero_reg) result_reg <= {opa_reg, {WIDTH{1'b1}}};
            else           result_reg <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_reg;

endmodule
